// File: rtl/sram_param_ctrl_if.sv
// Request/response bundle between the launchpad control FSM and sram_param_ctrl.
// Optional macro SRAM_PARITY_EN adds the ParErr response signal.
interface sram_param_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4
);
    logic              Req;
    logic              RW;
    logic              Clr;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;
    logic              Valid;
    logic              Busy;
    logic              Err;
`ifdef SRAM_PARITY_EN
    logic              ParErr;
`endif

`ifdef SRAM_PARITY_EN
    modport master (output Req, RW, Clr, Address, Din,
                    input  Dout, Valid, Busy, Err, ParErr);
    modport slave  (input  Req, RW, Clr, Address, Din,
                    output Dout, Valid, Busy, Err, ParErr);
`else
    modport master (output Req, RW, Clr, Address, Din,
                    input  Dout, Valid, Busy, Err);
    modport slave  (input  Req, RW, Clr, Address, Din,
                    output Dout, Valid, Busy, Err);
`endif
endinterface

// File: rtl/sram_param_ctrl.sv
// DEPTH x DATA_W flop-array SRAM with registered reads, clear sweep and range check.
// Optional macro SRAM_PARITY_EN stores an even-parity bit per word and reports ParErr.
module sram_param_ctrl #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input logic             CLK,
    input logic             RST,
    sram_param_ctrl_if.slave bus
);
`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
`ifdef SRAM_PARITY_EN
    logic              parerr_q, parerr_d;
`endif

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic              in_range;

`ifdef SRAM_PARITY_EN
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
    assign wr_word = {even_par(bus.Din), bus.Din};
`else
    assign wr_word = bus.Din;
`endif

    // Zero-extend by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, bus.Address} < DEPTH_X);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADDR_W'(i)) rd_word = mem_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = bus.Address;
        mem_wdata = wr_word;
`ifdef SRAM_PARITY_EN
        parerr_d  = 1'b0;
`endif
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_ADDR) state_d = IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            IDLE: begin
                if (bus.Clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (bus.Req) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (!bus.RW) begin
                            valid_d = 1'b1;
                            dout_d  = '0;
                        end
                    end else if (bus.RW) begin
                        mem_we = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        dout_d  = rd_word[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                        parerr_d = rd_word[MEM_W-1] != even_par(rd_word[DATA_W-1:0]);
`endif
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SRAM_PARITY_EN
            parerr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef SRAM_PARITY_EN
            parerr_q <= parerr_d;
`endif
        end
    end

    // Storage has no reset of its own; the post-reset sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (RST && mem_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_waddr == ADDR_W'(i)) mem_q[i] <= mem_wdata;
            end
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
    assign bus.Err   = err_q;
    assign bus.Busy  = (state_q == CLEAR);
`ifdef SRAM_PARITY_EN
    assign bus.ParErr = parerr_q;
`endif
endmodule
